if_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, drives the 6-bit word address of the

---
 rtl/if_stage_if.sv | 33 +++
 rtl/if_stage.sv | 104 ++++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// if_stage_if : ID-control, instruction-memory and IF/ID bundle of the fetch stage
// Rev 1.0
// ============================================================================
interface if_stage_if #(
  parameter int AW = 6
);
  logic          stall;
  logic          branch_taken;
  logic [15:0]   branch_offset;
  logic          jump;
  logic [25:0]   jump_target;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_data;
  logic [31:0]   pc;
  logic [31:0]   ifid_instr;
  logic [31:0]   ifid_pc4;
  logic          ifid_valid;
  logic [15:0]   fetch_count;
  logic          halted;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target, im_data,
    output im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count, halted
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target, im_data,
    input  im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count, halted
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : PC owner, instruction fetch and IF/ID register with stall/redirect/halt
// Rev 1.0
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_DEPTH = 64,
  parameter int          AW       = 6
) (
  input  wire        clk,
  input  wire        rst_n,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [31:0] C_PC_LIMIT = 32'(IM_DEPTH * 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic        halted_q, halted_d;

  logic        redirect_w;
  logic [31:0] target_w;
  logic [31:0] br_target_w;
  logic [31:0] j_target_w;

  // Redirect only applies to a real instruction held in IF/ID; jump beats branch.
  assign redirect_w  = valid_q & (bus.jump | bus.branch_taken);
  assign br_target_w = pc4_q + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign j_target_w  = {pc4_q[31:28], bus.jump_target, 2'b00};
  assign target_w    = bus.jump ? j_target_w : br_target_w;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    count_d  = count_q;
    halted_d = halted_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (redirect_w) begin
          pc_d    = target_w;
          instr_d = 32'h0;
          valid_d = 1'b0;
        end else if (pc_q >= C_PC_LIMIT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          instr_d  = 32'h0;
          valid_d  = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.im_data;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc4_q    <= 32'h0;
      valid_q  <= 1'b0;
      count_q  <= 16'h0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  assign bus.im_addr     = pc_q[AW+1:2];
  assign bus.pc          = pc_q;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc4    = pc4_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.fetch_count = count_q;
  assign bus.halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage : directed self-checking bench for if_stage
// Rev 1.0
// ============================================================================
module tb_if_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  logic [31:0] imem [0:63];

  always #5 clk = ~clk;

  if_stage_if #(.AW(6)) bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .IM_DEPTH (64),
    .AW       (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.im_data = imem[bus.im_addr];

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 26'h0;
  endtask

  // Reset then release; returns at the negedge right after release (0 edges run).
  task automatic reset_release();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    total++; if (bus.pc !== 32'h0) $display("FAIL reset_pc: got %h exp %h", bus.pc, 32'h0); else passed++;
    total++; if (bus.ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.ifid_valid); else passed++;
    total++; if (bus.ifid_instr !== 32'h0) $display("FAIL reset_instr: got %h exp 0", bus.ifid_instr); else passed++;
    total++; if (bus.fetch_count !== 16'h0) $display("FAIL reset_count: got %h exp 0", bus.fetch_count); else passed++;
    total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b exp 0", bus.halted); else passed++;
    total++; if (bus.im_addr !== 6'h0) $display("FAIL reset_imaddr: got %h exp 0", bus.im_addr); else passed++;
  endtask

  task automatic test_fetch();
    reset_release();
    run(1);
    total++; if (bus.ifid_valid !== 1'b0) $display("FAIL boot_bubble: got %b exp 0", bus.ifid_valid); else passed++;
    run(1);
    total++; if (bus.ifid_instr !== 32'h20080020) $display("FAIL fetch_e2_instr: got %h exp %h", bus.ifid_instr, 32'h20080020); else passed++;
    total++; if (bus.ifid_pc4 !== 32'h4) $display("FAIL fetch_e2_pc4: got %h exp 4", bus.ifid_pc4); else passed++;
    total++; if (bus.ifid_valid !== 1'b1) $display("FAIL fetch_e2_valid: got %b exp 1", bus.ifid_valid); else passed++;
    run(3);
    total++; if (bus.pc !== 32'h10) $display("FAIL fetch_e5_pc: got %h exp 10", bus.pc); else passed++;
    total++; if (bus.fetch_count !== 16'd4) $display("FAIL fetch_e5_count: got %0d exp 4", bus.fetch_count); else passed++;
    total++; if (bus.ifid_instr !== 32'h01098822) $display("FAIL fetch_e5_instr: got %h exp %h", bus.ifid_instr, 32'h01098822); else passed++;
    total++; if (bus.im_addr !== 6'h4) $display("FAIL fetch_e5_imaddr: got %h exp 4", bus.im_addr); else passed++;
  endtask

  task automatic test_stall();
    reset_release();
    run(3);
    total++; if (bus.pc !== 32'h8) $display("FAIL stall_pre_pc: got %h exp 8", bus.pc); else passed++;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(1);
      total++; if (bus.pc !== 32'h8) $display("FAIL stall_pc[%0d]: got %h exp 8", i, bus.pc); else passed++;
      total++; if (bus.ifid_instr !== 32'h20090037) $display("FAIL stall_instr[%0d]: got %h exp %h", i, bus.ifid_instr, 32'h20090037); else passed++;
      total++; if (bus.fetch_count !== 16'd2) $display("FAIL stall_count[%0d]: got %0d exp 2", i, bus.fetch_count); else passed++;
    end
    bus.stall = 1'b0;
    run(1);
    total++; if (bus.ifid_instr !== 32'h01098020) $display("FAIL stall_resume_instr: got %h exp %h", bus.ifid_instr, 32'h01098020); else passed++;
    total++; if (bus.pc !== 32'hC) $display("FAIL stall_resume_pc: got %h exp c", bus.pc); else passed++;
    total++; if (bus.fetch_count !== 16'd3) $display("FAIL stall_resume_count: got %0d exp 3", bus.fetch_count); else passed++;
  endtask

  task automatic test_branch(input logic with_stall);
    reset_release();
    run(9);
    total++; if (bus.ifid_pc4 !== 32'h20) $display("FAIL br_setup_pc4: got %h exp 20", bus.ifid_pc4); else passed++;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'hFFFE;
    bus.stall         = with_stall;
    run(1);
    clear_inputs();
    total++; if (bus.pc !== 32'h18) $display("FAIL br_pc(stall=%0b): got %h exp 18", with_stall, bus.pc); else passed++;
    total++; if (bus.ifid_valid !== 1'b0) $display("FAIL br_valid(stall=%0b): got %b exp 0", with_stall, bus.ifid_valid); else passed++;
    total++; if (bus.ifid_instr !== 32'h0) $display("FAIL br_instr(stall=%0b): got %h exp 0", with_stall, bus.ifid_instr); else passed++;
    total++; if (bus.fetch_count !== 16'd8) $display("FAIL br_count(stall=%0b): got %0d exp 8", with_stall, bus.fetch_count); else passed++;
  endtask

  task automatic test_jump();
    reset_release();
    run(17);
    total++; if (bus.ifid_pc4 !== 32'h40) $display("FAIL j_setup_pc4: got %h exp 40", bus.ifid_pc4); else passed++;
    bus.jump          = 1'b1;
    bus.jump_target   = 26'h6;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0010;
    run(1);
    total++; if (bus.pc !== 32'h18) $display("FAIL j_wins_pc: got %h exp 18", bus.pc); else passed++;
    // IF/ID now a bubble: the same control inputs must be ignored
    run(1);
    clear_inputs();
    total++; if (bus.pc !== 32'h1C) $display("FAIL j_ignored_pc: got %h exp 1c", bus.pc); else passed++;
    total++; if (bus.ifid_valid !== 1'b1) $display("FAIL j_ignored_valid: got %b exp 1", bus.ifid_valid); else passed++;
    total++; if (bus.ifid_instr !== imem[6]) $display("FAIL j_ignored_instr: got %h exp %h", bus.ifid_instr, imem[6]); else passed++;
  endtask

  task automatic test_halt();
    reset_release();
    run(65);
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_early: got %b exp 0", bus.halted); else passed++;
    total++; if (bus.pc !== 32'h100) $display("FAIL halt_pre_pc: got %h exp 100", bus.pc); else passed++;
    run(1);
    total++; if (bus.halted !== 1'b1) $display("FAIL halt_flag: got %b exp 1", bus.halted); else passed++;
    total++; if (bus.fetch_count !== 16'd64) $display("FAIL halt_count: got %0d exp 64", bus.fetch_count); else passed++;
    total++; if (bus.ifid_valid !== 1'b0) $display("FAIL halt_valid: got %b exp 0", bus.ifid_valid); else passed++;
    bus.jump = 1'b1;
    bus.jump_target = 26'h3;
    bus.branch_taken = 1'b1;
    run(3);
    clear_inputs();
    total++; if (bus.pc !== 32'h100) $display("FAIL halt_frozen_pc: got %h exp 100", bus.pc); else passed++;
    total++; if (bus.halted !== 1'b1) $display("FAIL halt_stays: got %b exp 1", bus.halted); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.pc !== 32'h0) $display("FAIL halt_async_pc: got %h exp 0", bus.pc); else passed++;
    total++; if (bus.halted !== 1'b0) $display("FAIL halt_async_halted: got %b exp 0", bus.halted); else passed++;
    total++; if (bus.fetch_count !== 16'h0) $display("FAIL halt_async_count: got %h exp 0", bus.fetch_count); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    total++; if (bus.ifid_pc4 !== 32'h4) $display("FAIL halt_reboot_pc4: got %h exp 4", bus.ifid_pc4); else passed++;
  endtask

  task automatic test_saturate();
    reset_release();
    bus.stall = 1'b1;
    run(2);
    force dut.count_q = 16'hFFFE;
    run(1);
    release dut.count_q;
    run(1);
    total++; if (bus.fetch_count !== 16'hFFFE) $display("FAIL sat_forced: got %h exp fffe", bus.fetch_count); else passed++;
    bus.stall = 1'b0;
    run(1);
    total++; if (bus.fetch_count !== 16'hFFFF) $display("FAIL sat_first: got %h exp ffff", bus.fetch_count); else passed++;
    run(1);
    total++; if (bus.fetch_count !== 16'hFFFF) $display("FAIL sat_hold: got %h exp ffff", bus.fetch_count); else passed++;
    total++; if (bus.pc !== 32'h8) $display("FAIL sat_pc: got %h exp 8", bus.pc); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 | 32'(i);
    imem[0] = 32'h20080020;
    imem[1] = 32'h20090037;
    imem[2] = 32'h01098020;
    imem[3] = 32'h01098822;
    clear_inputs();
    test_reset();
    test_fetch();
    test_stall();
    test_branch(1'b0);
    test_branch(1'b1);
    test_jump();
    test_halt();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
